// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions.
// Provides the cache-line type and the state encoding used by the
// cache/memory arbiter.
package lc3b_types;

  typedef logic [127:0] lc3b_c_line;

  // Arbiter states: idle, memory transaction in flight for I or D,
  // one-cycle response back to I or D.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StBusyI = 3'd1,
    StBusyD = 3'd2,
    StRespI = 3'd3,
    StRespD = 3'd4
  } arb_state_t;

endpackage

// File: rtl/arb_line_reg.sv
// Loadable line-wide register with asynchronous active-high reset to zero.
// Ports:
//   clk    - clock
//   reset  - asynchronous, active-high; clears q
//   load   - capture d on the rising edge
//   d      - next line value
//   q      - held line value
module arb_line_reg #(
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LINE_W-1:0] d,
  output logic [LINE_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single physical-memory line port between the icache and
// dcache miss interfaces. One requester is granted at a time; address, write
// line and operation are registered for the whole transaction. The returned
// line is captured per side and a one-cycle resp is sent to the granted cache.
// Simultaneous requests are resolved round-robin via last_i_q.
// Ports:
//   clk, reset                       - clock, async active-high reset
//   i_read, i_address                - icache line-fill request
//   i_rdata, i_resp                  - line and completion pulse to icache
//   d_read, d_write, d_address,
//   d_wdata                          - dcache fill / write-back request
//   d_rdata, d_resp                  - line and completion pulse to dcache
//   mem_read, mem_write, mem_address,
//   mem_wdata                        - registered memory-side request
//   mem_rdata, mem_resp              - memory read line and completion
//   busy                             - high whenever not idle
module cache_mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              last_i_q, last_i_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              wdata_load;
  logic              i_load;
  logic              d_load;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;

  assign d_req = d_read | d_write;
  // last_i_q set means I won the previous grant, so D wins a tie.
  assign grant_d = d_req & (~i_read | last_i_q);
  assign grant_i = i_read & (~d_req | ~last_i_q);

  always_comb begin
    state_d       = state_q;
    last_i_d      = last_i_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    wdata_load    = 1'b0;
    i_load        = 1'b0;
    d_load        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d       = StBusyD;
          last_i_d      = 1'b0;
          // read+write together is treated as a write
          mem_write_d   = d_write;
          mem_read_d    = ~d_write;
          mem_address_d = d_address;
          wdata_load    = 1'b1;
        end else if (grant_i) begin
          state_d       = StBusyI;
          last_i_d      = 1'b1;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
          mem_address_d = i_address;
        end
      end
      StBusyI: begin
        if (mem_resp) begin
          i_load      = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = StRespI;
        end
      end
      StBusyD: begin
        if (mem_resp) begin
          // write-backs leave d_rdata untouched
          d_load      = mem_read_q;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = StRespD;
        end
      end
      StRespI, StRespD: begin
        state_d = StIdle;
      end
      default: begin
        state_d     = StIdle;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      last_i_q      <= 1'b1;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
    end else begin
      state_q       <= state_d;
      last_i_q      <= last_i_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
    end
  end

  arb_line_reg #(
    .LINE_W(LINE_W)
  ) u_wdata_reg (
    .clk  (clk),
    .reset(reset),
    .load (wdata_load),
    .d    (d_wdata),
    .q    (mem_wdata)
  );

  arb_line_reg #(
    .LINE_W(LINE_W)
  ) u_i_rdata_reg (
    .clk  (clk),
    .reset(reset),
    .load (i_load),
    .d    (mem_rdata),
    .q    (i_rdata)
  );

  arb_line_reg #(
    .LINE_W(LINE_W)
  ) u_d_rdata_reg (
    .clk  (clk),
    .reset(reset),
    .load (d_load),
    .d    (mem_rdata),
    .q    (d_rdata)
  );

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign i_resp      = (state_q == StRespI);
  assign d_resp      = (state_q == StRespD);
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int LAT    = 3;

  logic              clk;
  logic              reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              busy;

  int checks;
  int failures;
  int mem_cnt;

  cache_mem_arbiter #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency memory: resp during the LAT-th cycle a strobe is high.
  always @(posedge clk or posedge reset) begin
    if (reset) mem_cnt <= 0;
    else if (mem_read || mem_write) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end
  assign mem_resp = (mem_read || mem_write) && (mem_cnt == LAT - 1);

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for resp on one side, counting strobe cycles and resp pulses seen;
  // drops that side's request at the negedge where resp is observed.
  task automatic wait_resp(input bit side_d, output int rd_cyc, output int wr_cyc,
                           output int other_resp);
    bit got;
    got        = 1'b0;
    rd_cyc     = 0;
    wr_cyc     = 0;
    other_resp = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (mem_read) rd_cyc++;
      if (mem_write) wr_cyc++;
      if (side_d ? i_resp : d_resp) other_resp++;
      if (side_d ? d_resp : i_resp) begin
        got = 1'b1;
        if (side_d) begin
          d_read  = 1'b0;
          d_write = 1'b0;
        end else begin
          i_read = 1'b0;
        end
      end
    end
    check_eq("resp_seen", {127'd0, got}, 128'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int rd, wr, oth;
  logic [LINE_W-1:0] line_a5, line_5a, line_wb, line_ff;

  initial begin
    checks    = 0;
    failures  = 0;
    i_read    = 1'b0;
    i_address = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_address = '0;
    d_wdata   = '0;
    line_a5   = {16{8'hA5}};
    line_5a   = {16{8'h5A}};
    line_ff   = {16{8'hFF}};
    line_wb   = 128'h0123456789ABCDEF0123456789ABCDEF;
    mem_rdata = '0;

    // Reset values
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", {127'd0, busy}, 128'd0);
    check_eq("rst_strobes", {126'd0, mem_read, mem_write}, 128'd0);
    check_eq("rst_resps", {126'd0, i_resp, d_resp}, 128'd0);
    check_eq("rst_addr", {112'd0, mem_address}, 128'd0);
    check_eq("rst_wdata", mem_wdata, 128'd0);
    check_eq("rst_i_rdata", i_rdata, 128'd0);
    check_eq("rst_d_rdata", d_rdata, 128'd0);
    reset = 1'b0;

    // I-only read at 0x1230
    @(negedge clk);
    i_read    = 1'b1;
    i_address = 16'h1230;
    mem_rdata = line_a5;
    @(posedge clk);
    wait_resp(1'b0, rd, wr, oth);
    check_eq("i_rd_cycles", 128'(rd), 128'd3);
    check_eq("i_wr_cycles", 128'(wr), 128'd0);
    check_eq("i_addr", {112'd0, mem_address}, 128'h1230);
    check_eq("i_rdata", i_rdata, line_a5);
    check_eq("i_d_rdata_0", d_rdata, 128'd0);
    @(negedge clk);
    check_eq("i_resp_once", {127'd0, i_resp}, 128'd0);
    check_eq("i_idle", {127'd0, busy}, 128'd0);

    // Tie after reset: D, then I, then D
    do_reset();
    i_read    = 1'b1;
    i_address = 16'h1000;
    d_read    = 1'b1;
    d_address = 16'h2000;
    mem_rdata = line_5a;
    @(posedge clk);
    @(negedge clk);
    check_eq("tie1_addr", {112'd0, mem_address}, 128'h2000);
    wait_resp(1'b1, rd, wr, oth);
    check_eq("tie1_rd_cycles", 128'(rd), 128'd2);
    check_eq("tie1_d_rdata", d_rdata, line_5a);
    check_eq("tie1_i_rdata", i_rdata, 128'd0);
    @(negedge clk);
    check_eq("tie1_gap", {127'd0, busy}, 128'd0);
    d_read    = 1'b1;
    mem_rdata = line_a5;
    @(negedge clk);
    check_eq("tie2_addr", {112'd0, mem_address}, 128'h1000);
    wait_resp(1'b0, rd, wr, oth);
    check_eq("tie2_i_rdata", i_rdata, line_a5);
    check_eq("tie2_d_rdata", d_rdata, line_5a);
    @(negedge clk);
    check_eq("tie2_gap", {127'd0, busy}, 128'd0);
    i_read    = 1'b1;
    mem_rdata = line_ff;
    @(negedge clk);
    check_eq("tie3_addr", {112'd0, mem_address}, 128'h2000);
    wait_resp(1'b1, rd, wr, oth);
    check_eq("tie3_d_rdata", d_rdata, line_ff);
    check_eq("tie3_no_i_resp", 128'(oth), 128'd0);
    // I still pending: it must be granted next
    @(negedge clk);
    @(negedge clk);
    check_eq("tie3_i_next", {112'd0, mem_address}, 128'h1000);
    wait_resp(1'b0, rd, wr, oth);
    @(negedge clk);

    // D write-back to 0x4000
    d_write   = 1'b1;
    d_address = 16'h4000;
    d_wdata   = line_wb;
    mem_rdata = line_5a;
    @(posedge clk);
    wait_resp(1'b1, rd, wr, oth);
    check_eq("wb_wr_cycles", 128'(wr), 128'd3);
    check_eq("wb_rd_cycles", 128'(rd), 128'd0);
    check_eq("wb_addr", {112'd0, mem_address}, 128'h4000);
    check_eq("wb_wdata", mem_wdata, line_wb);
    check_eq("wb_d_rdata", d_rdata, line_ff);
    @(negedge clk);
    check_eq("wb_resp_once", {127'd0, d_resp}, 128'd0);

    // d_read and d_write together is a write
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 16'h4010;
    @(posedge clk);
    wait_resp(1'b1, rd, wr, oth);
    check_eq("rw_wr_cycles", 128'(wr), 128'd3);
    check_eq("rw_rd_cycles", 128'(rd), 128'd0);
    check_eq("rw_d_rdata", d_rdata, line_ff);
    @(negedge clk);

    // Reset mid BUSY_I
    i_read    = 1'b1;
    i_address = 16'h3000;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_pre", {127'd0, mem_read}, 128'd1);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    i_read = 1'b0;
    #1;
    check_eq("abort_strobe", {127'd0, mem_read}, 128'd0);
    check_eq("abort_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    check_eq("abort_no_resp", {127'd0, i_resp}, 128'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_no_resp2", {127'd0, i_resp}, 128'd0);
    // last_i is back to 1: D wins the next tie
    i_read    = 1'b1;
    i_address = 16'h1100;
    d_read    = 1'b1;
    d_address = 16'h2200;
    @(negedge clk);
    check_eq("abort_tie", {112'd0, mem_address}, 128'h2200);
    wait_resp(1'b1, rd, wr, oth);
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_tie_i", {112'd0, mem_address}, 128'h1100);
    wait_resp(1'b0, rd, wr, oth);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
